// File: rtl/ultrasonic_pwm_core_if.sv
// Configuration bus from the AXI4-Lite register slave into the PWM core:
// staged period/phase/duty writes, the commit strobe and its pending flag.
interface ultrasonic_pwm_core_if #(
    parameter int CNT_W = 16,
    parameter int CH_W  = 3
);
    logic [CNT_W-1:0] cfg_period;
    logic             cfg_wr;
    logic [CH_W-1:0]  cfg_ch;
    logic [CNT_W-1:0] cfg_phase;
    logic [CNT_W-1:0] cfg_duty;
    logic             commit;
    logic             commit_pending;

    modport master (
        output cfg_period, cfg_wr, cfg_ch, cfg_phase, cfg_duty, commit,
        input  commit_pending
    );

    modport slave (
        input  cfg_period, cfg_wr, cfg_ch, cfg_phase, cfg_duty, commit,
        output commit_pending
    );
endinterface

// File: rtl/ultrasonic_pwm_core.sv
// Multi-channel phase-shifted PWM engine with double-buffered configuration.
// Staged settings become active only at a period boundary (or at once when idle).
module ultrasonic_pwm_core #(
    parameter int NUM_CH         = 8,
    parameter int CNT_W          = 16,
    parameter int CH_W           = 3,
    parameter int DEFAULT_PERIOD = 2500
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic                  enable,
    ultrasonic_pwm_core_if.slave  cfg,
    output logic                  sync_out,
    output logic [CNT_W-1:0]      cnt_out,
    output logic [NUM_CH-1:0]     pwm_out
);

    localparam logic [CNT_W-1:0] LP_DEFAULT_PERIOD = CNT_W'(DEFAULT_PERIOD);
    localparam logic [CNT_W-1:0] LP_MIN_PERIOD     = CNT_W'(2);

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_act_period;
    logic [CNT_W-1:0] r_stg_period;
    logic [CNT_W-1:0] r_act_phase [NUM_CH];
    logic [CNT_W-1:0] r_act_duty  [NUM_CH];
    logic [CNT_W-1:0] r_stg_phase [NUM_CH];
    logic [CNT_W-1:0] r_stg_duty  [NUM_CH];

    logic [CNT_W-1:0] w_new_period;
    logic [CNT_W-1:0] w_new_phase [NUM_CH];
    logic [CNT_W-1:0] w_new_duty  [NUM_CH];
    logic [CNT_W:0]   w_rel       [NUM_CH];
    logic [NUM_CH-1:0] w_hi;

    logic             w_wrap;
    logic             w_transfer;
    logic             w_ch_valid;

    logic [NUM_CH-1:0] r_pwm;
    logic              r_sync;

    // Active period is never below 2, so the subtraction cannot underflow.
    assign w_wrap     = (r_cnt >= (r_act_period - CNT_W'(1)));
    assign w_transfer = (r_state == ST_PENDING) && (!enable || w_wrap);
    assign w_ch_valid = (32'(cfg.cfg_ch) < NUM_CH);

    // ------------------------------------------------------------------
    // Commit tracking: a commit always (re)arms the pending state, so one
    // landing on the transfer edge stays pending for the next boundary.
    // ------------------------------------------------------------------
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: every combinational output gets a default before any branch so
    // no path leaves it unassigned, which would infer a latch.
    always_comb begin
        w_state_next = r_state;
        if (cfg.commit) begin
            w_state_next = ST_PENDING;
        end else if (w_transfer) begin
            w_state_next = ST_IDLE;
        end
    end

    assign cfg.commit_pending = (r_state == ST_PENDING);

    // ------------------------------------------------------------------
    // Sanitised values loaded into the active set on a transfer.
    // ------------------------------------------------------------------
    assign w_new_period = (r_stg_period < LP_MIN_PERIOD) ? LP_MIN_PERIOD : r_stg_period;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            w_new_phase[i] = (r_stg_phase[i] >= w_new_period) ? '0 : r_stg_phase[i];
            w_new_duty[i]  = (r_stg_duty[i] > w_new_period) ? w_new_period : r_stg_duty[i];
        end
    end

    // ------------------------------------------------------------------
    // Period counter: held at 0 while disabled, wraps at P-1.
    // ------------------------------------------------------------------
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_cnt <= '0;
        end else if (!enable || w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign cnt_out = r_cnt;

    // ------------------------------------------------------------------
    // Staging registers. They are written after the transfer reads them
    // on the same edge, so a coinciding write waits for the next commit.
    // ------------------------------------------------------------------
    // NOTE: the configuration arrays are reset explicitly; every entry must
    // come up as phase 0 / duty 0 so no gate fires before configuration.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_stg_period <= LP_DEFAULT_PERIOD;
            for (int i = 0; i < NUM_CH; i++) begin
                r_stg_phase[i] <= '0;
                r_stg_duty[i]  <= '0;
            end
        end else begin
            if (cfg.commit) begin
                r_stg_period <= cfg.cfg_period;
            end
            if (cfg.cfg_wr && w_ch_valid) begin
                r_stg_phase[cfg.cfg_ch] <= cfg.cfg_phase;
                r_stg_duty[cfg.cfg_ch]  <= cfg.cfg_duty;
            end
        end
    end

    // ------------------------------------------------------------------
    // Active set, updated only on a transfer.
    // ------------------------------------------------------------------
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_act_period <= LP_DEFAULT_PERIOD;
            for (int i = 0; i < NUM_CH; i++) begin
                r_act_phase[i] <= '0;
                r_act_duty[i]  <= '0;
            end
        end else if (w_transfer) begin
            r_act_period <= w_new_period;
            for (int i = 0; i < NUM_CH; i++) begin
                r_act_phase[i] <= w_new_phase[i];
                r_act_duty[i]  <= w_new_duty[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-channel compare; the extra bit keeps cnt+P from overflowing.
    // ------------------------------------------------------------------
    always_comb begin
        w_hi = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (r_cnt >= r_act_phase[i]) begin
                w_rel[i] = {1'b0, r_cnt} - {1'b0, r_act_phase[i]};
            end else begin
                w_rel[i] = {1'b0, r_cnt} + {1'b0, r_act_period} - {1'b0, r_act_phase[i]};
            end
            w_hi[i] = (w_rel[i] < {1'b0, r_act_duty[i]});
        end
    end

    // Gate outputs and sync are registered together so they stay aligned.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_pwm  <= '0;
            r_sync <= 1'b0;
        end else begin
            r_pwm  <= enable ? w_hi : '0;
            r_sync <= enable && (r_cnt == '0);
        end
    end

    assign pwm_out  = r_pwm;
    assign sync_out = r_sync;

endmodule

// File: tb/tb_ultrasonic_pwm_core.sv
// Self-checking bench for ultrasonic_pwm_core: a cycle model pushes the
// expected outputs for every clock edge; each scenario pops and compares.
module tb_ultrasonic_pwm_core;

    localparam int NUM_CH = 8;
    localparam int CNT_W  = 16;
    localparam int CH_W   = 3;

    typedef struct packed {
        logic [NUM_CH-1:0] pwm;
        logic              sync;
        logic [CNT_W-1:0]  cnt;
        logic              pend;
    } exp_t;

    logic              ACLK   = 1'b0;
    logic              ARESET = 1'b1;
    logic              enable = 1'b0;
    logic              sync_out;
    logic [CNT_W-1:0]  cnt_out;
    logic [NUM_CH-1:0] pwm_out;

    ultrasonic_pwm_core_if #(.CNT_W(CNT_W), .CH_W(CH_W)) cfg_if ();

    ultrasonic_pwm_core #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W), .CH_W(CH_W), .DEFAULT_PERIOD(2500)
    ) dut (
        .ACLK    (ACLK),
        .ARESET  (ARESET),
        .enable  (enable),
        .cfg     (cfg_if),
        .sync_out(sync_out),
        .cnt_out (cnt_out),
        .pwm_out (pwm_out)
    );

    always #5 ACLK = ~ACLK;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model state
    int m_cnt  = 0;
    int m_p    = 2500;
    int s_p    = 2500;
    bit m_pend = 1'b0;
    int m_ph[NUM_CH];
    int m_du[NUM_CH];
    int s_ph[NUM_CH];
    int s_du[NUM_CH];

    initial begin
        for (int i = 0; i < NUM_CH; i++) begin
            m_ph[i] = 0; m_du[i] = 0; s_ph[i] = 0; s_du[i] = 0;
        end
    end

    always @(posedge ACLK) begin : model
        exp_t e;
        int   rel;
        int   np;
        bit   xfer;
        e = '0;
        if (ARESET) begin
            m_cnt = 0; m_p = 2500; s_p = 2500; m_pend = 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                m_ph[i] = 0; m_du[i] = 0; s_ph[i] = 0; s_du[i] = 0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (enable) begin
                    rel = (m_cnt + m_p - m_ph[i]) % m_p;
                    e.pwm[i] = (rel < m_du[i]);
                end
            end
            e.sync = enable && (m_cnt == 0);
            xfer   = m_pend && (!enable || (m_cnt == m_p - 1));
            m_cnt  = enable ? ((m_cnt + 1) % m_p) : 0;
            if (xfer) begin
                np = (s_p < 2) ? 2 : s_p;
                for (int i = 0; i < NUM_CH; i++) begin
                    m_ph[i] = (s_ph[i] >= np) ? 0 : s_ph[i];
                    m_du[i] = (s_du[i] > np) ? np : s_du[i];
                end
                m_p = np;
            end
            if (cfg_if.commit) m_pend = 1'b1;
            else if (xfer)     m_pend = 1'b0;
            if (cfg_if.cfg_wr && int'(cfg_if.cfg_ch) < NUM_CH) begin
                s_ph[cfg_if.cfg_ch] = int'(cfg_if.cfg_phase);
                s_du[cfg_if.cfg_ch] = int'(cfg_if.cfg_duty);
            end
            if (cfg_if.commit) s_p = int'(cfg_if.cfg_period);
            e.cnt  = CNT_W'(m_cnt);
            e.pend = m_pend;
        end
        sb_q.push_back(e);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "bench did not finish");
    end

    // ---------------- stimulus helpers (no checking) ----------------
    function automatic exp_t obs();
        return {pwm_out, sync_out, cnt_out, cfg_if.commit_pending};
    endfunction

    task automatic set_idle();
        cfg_if.cfg_wr = 1'b0;
        cfg_if.commit = 1'b0;
    endtask

    task automatic wr(input int ch, input int ph, input int du);
        cfg_if.cfg_wr    = 1'b1;
        cfg_if.cfg_ch    = CH_W'(ch);
        cfg_if.cfg_phase = CNT_W'(ph);
        cfg_if.cfg_duty  = CNT_W'(du);
    endtask

    task automatic do_commit(input int p);
        cfg_if.commit     = 1'b1;
        cfg_if.cfg_period = CNT_W'(p);
    endtask

    task automatic next_cycle(output exp_t e, output bit got);
        @(posedge ACLK);
        #1;
        got = (sb_q.size() > 0);
        e   = '0;
        if (got) e = sb_q.pop_front();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        exp_t e; bit got;
        ARESET = 1'b1; enable = 1'b0; set_idle();
        cfg_if.cfg_ch = '0; cfg_if.cfg_phase = '0; cfg_if.cfg_duty = '0; cfg_if.cfg_period = '0;
        for (int k = 0; k < 2; k++) begin
            next_cycle(e, got);
            checks++;
            if (!got || obs() !== e) begin
                failures++; $display("FAIL reset_cyc%0d got=%h want=%h", k, obs(), e);
            end
        end
        checks++; if (pwm_out !== '0)  begin failures++; $display("FAIL reset_pwm got=%h want=0", pwm_out); end
        checks++; if (sync_out !== 0)  begin failures++; $display("FAIL reset_sync got=%b want=0", sync_out); end
        checks++; if (cnt_out !== '0)  begin failures++; $display("FAIL reset_cnt got=%0d want=0", cnt_out); end
        checks++; if (cfg_if.commit_pending !== 0) begin
            failures++; $display("FAIL reset_pending got=%b want=0", cfg_if.commit_pending);
        end
        ARESET = 1'b0;
    endtask

    task automatic test_basic();
        exp_t e; bit got;
        for (int k = 0; k < 25; k++) begin
            set_idle();
            if (k == 0) begin wr(0, 0, 5); do_commit(10); end
            if (k == 2) enable = 1'b1;
            next_cycle(e, got);
            checks++;
            if (!got || obs() !== e) begin
                failures++; $display("FAIL basic_cyc%0d got=%h want=%h", k, obs(), e);
            end
        end
    endtask

    task automatic test_phase();
        exp_t e; bit got;
        for (int k = 0; k < 35; k++) begin
            set_idle();
            if (k == 0) wr(1, 3, 5);
            if (k == 1) wr(2, 8, 4);
            if (k == 2) do_commit(10);
            next_cycle(e, got);
            checks++;
            if (!got || obs() !== e) begin
                failures++; $display("FAIL phase_cyc%0d got=%h want=%h", k, obs(), e);
            end
        end
    endtask

    task automatic test_saturate();
        exp_t e; bit got;
        for (int k = 0; k < 35; k++) begin
            set_idle();
            if (k == 0) wr(3, 0, 0);
            if (k == 1) wr(4, 0, 12);
            if (k == 2) wr(5, 15, 3);
            if (k == 3) do_commit(10);
            next_cycle(e, got);
            checks++;
            if (!got || obs() !== e) begin
                failures++; $display("FAIL sat_cyc%0d got=%h want=%h", k, obs(), e);
            end
        end
        checks++;
        if (pwm_out[4:3] !== 2'b10) begin
            failures++; $display("FAIL sat_ch4hi_ch3lo got=%b want=10", pwm_out[4:3]);
        end
    endtask

    task automatic test_midperiod_commit();
        exp_t e; bit got; int guard;
        set_idle();
        guard = 0;
        while (cnt_out !== CNT_W'(3) && guard < 20) begin
            next_cycle(e, got);
            checks++;
            if (!got || obs() !== e) begin
                failures++; $display("FAIL midp_wait got=%h want=%h", obs(), e);
            end
            guard++;
        end
        checks++;
        if (cnt_out !== CNT_W'(3)) begin failures++; $display("FAIL midp_reach_cnt3 got=%0d want=3", cnt_out); end
        for (int k = 0; k < 25; k++) begin
            set_idle();
            if (k == 0) begin wr(0, 4, 5); do_commit(10); end
            next_cycle(e, got);
            checks++;
            if (!got || obs() !== e) begin
                failures++; $display("FAIL midp_cyc%0d got=%h want=%h", k, obs(), e);
            end
        end
    endtask

    task automatic test_write_at_transfer();
        exp_t e; bit got; int guard;
        set_idle(); do_commit(10);
        next_cycle(e, got);
        checks++;
        if (!got || obs() !== e) begin failures++; $display("FAIL wat_commit got=%h want=%h", obs(), e); end
        set_idle();
        guard = 0;
        while (cnt_out !== CNT_W'(9) && guard < 20) begin
            next_cycle(e, got);
            checks++;
            if (!got || obs() !== e) begin failures++; $display("FAIL wat_wait got=%h want=%h", obs(), e); end
            guard++;
        end
        checks++;
        if (cnt_out !== CNT_W'(9)) begin failures++; $display("FAIL wat_reach_cnt9 got=%0d want=9", cnt_out); end
        for (int k = 0; k < 40; k++) begin
            set_idle();
            if (k == 0)  wr(0, 4, 2);
            if (k == 12) do_commit(10);
            next_cycle(e, got);
            checks++;
            if (!got || obs() !== e) begin
                failures++; $display("FAIL wat_cyc%0d got=%h want=%h", k, obs(), e);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e; bit got; int guard;
        set_idle(); do_commit(10);
        next_cycle(e, got);
        checks++;
        if (!got || obs() !== e) begin failures++; $display("FAIL b2b_commit got=%h want=%h", obs(), e); end
        set_idle();
        guard = 0;
        while (cnt_out !== CNT_W'(9) && guard < 20) begin
            next_cycle(e, got);
            checks++;
            if (!got || obs() !== e) begin failures++; $display("FAIL b2b_wait got=%h want=%h", obs(), e); end
            guard++;
        end
        do_commit(10);
        next_cycle(e, got);
        checks++;
        if (!got || obs() !== e) begin failures++; $display("FAIL b2b_xfer got=%h want=%h", obs(), e); end
        checks++;
        if (cfg_if.commit_pending !== 1'b1) begin
            failures++; $display("FAIL b2b_still_pending got=%b want=1", cfg_if.commit_pending);
        end
        for (int k = 0; k < 12; k++) begin
            set_idle();
            next_cycle(e, got);
            checks++;
            if (!got || obs() !== e) begin
                failures++; $display("FAIL b2b_cyc%0d got=%h want=%h", k, obs(), e);
            end
        end
        checks++;
        if (cfg_if.commit_pending !== 1'b0) begin
            failures++; $display("FAIL b2b_cleared got=%b want=0", cfg_if.commit_pending);
        end
    endtask

    task automatic test_reset_midrun();
        exp_t e; bit got; int guard;
        set_idle();
        guard = 0;
        while (cnt_out !== CNT_W'(4) && guard < 20) begin
            next_cycle(e, got);
            checks++;
            if (!got || obs() !== e) begin failures++; $display("FAIL rst_wait got=%h want=%h", obs(), e); end
            guard++;
        end
        wr(0, 0, 5); do_commit(10);
        next_cycle(e, got);
        checks++;
        if (!got || obs() !== e) begin failures++; $display("FAIL rst_commit got=%h want=%h", obs(), e); end
        checks++;
        if (cfg_if.commit_pending !== 1'b1) begin
            failures++; $display("FAIL rst_pending_before got=%b want=1", cfg_if.commit_pending);
        end
        set_idle(); ARESET = 1'b1;
        next_cycle(e, got);
        checks++;
        if (!got || obs() !== e) begin failures++; $display("FAIL rst_edge got=%h want=%h", obs(), e); end
        checks++; if (pwm_out !== '0) begin failures++; $display("FAIL rst_mid_pwm got=%h want=0", pwm_out); end
        checks++; if (cnt_out !== '0) begin failures++; $display("FAIL rst_mid_cnt got=%0d want=0", cnt_out); end
        checks++;
        if (cfg_if.commit_pending !== 1'b0) begin
            failures++; $display("FAIL rst_mid_pending got=%b want=0", cfg_if.commit_pending);
        end
        ARESET = 1'b0;
        for (int k = 0; k < 15; k++) begin
            next_cycle(e, got);
            checks++;
            if (!got || obs() !== e) begin
                failures++; $display("FAIL rst_run_cyc%0d got=%h want=%h", k, obs(), e);
            end
        end
        checks++;
        if (cnt_out !== CNT_W'(15)) begin failures++; $display("FAIL rst_default_period cnt got=%0d want=15", cnt_out); end
    endtask

    task automatic test_min_period();
        exp_t e; bit got;
        for (int k = 0; k < 14; k++) begin
            set_idle();
            if (k == 0) begin enable = 1'b0; wr(0, 5, 1); do_commit(1); end
            if (k == 2) enable = 1'b1;
            next_cycle(e, got);
            checks++;
            if (!got || obs() !== e) begin
                failures++; $display("FAIL minp_cyc%0d got=%h want=%h", k, obs(), e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_phase();
        test_saturate();
        test_midperiod_commit();
        test_write_at_transfer();
        test_back_to_back();
        test_reset_midrun();
        test_min_period();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
